// File: rtl/grf_mp.sv
// Multi-port general register file: two write ports, NUM_RD combinational read
// ports with optional write bypass, and a per-register busy scoreboard.
module grf_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     issue_en,
   input  logic [ADDR_W-1:0]        issue_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [ADDR_W:0]          busy_count
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              we0, we1, iss, byp_en;
   logic              inc, dec0, dec1;

   // Register 0 is dropped from writes and issues when hardwired to zero.
   assign we0    = wr0_en   && !((ZERO_REG != 0) && (wr0_addr   == '0));
   assign we1    = wr1_en   && !((ZERO_REG != 0) && (wr1_addr   == '0));
   assign iss    = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
   assign byp_en = (BYPASS != 0) && !reset;

   always_comb begin
      busy_d = busy_q;
      if (we0) busy_d[wr0_addr] = 1'b0;
      if (we1) busy_d[wr1_addr] = 1'b0;
      if (iss) busy_d[issue_addr] = 1'b1;
   end

   // Count tracks busy_d incrementally; each address is counted once even when ports collide.
   assign inc  = iss && !busy_q[issue_addr];
   assign dec0 = we0 && busy_q[wr0_addr] && !(iss && (issue_addr == wr0_addr));
   assign dec1 = we1 && busy_q[wr1_addr] && !(iss && (issue_addr == wr1_addr))
                 && !(we0 && (wr0_addr == wr1_addr));
   assign cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         if (we0) regs_q[wr0_addr] <= wr0_data;
         if (we1) regs_q[wr1_addr] <= wr1_data;
      end
   end

   assign busy_count = cnt_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero, hit0, hit1;
      assign a    = rd_addr[k*ADDR_W +: ADDR_W];
      assign zero = (ZERO_REG != 0) && (a == '0);
      assign hit0 = byp_en && we0 && (wr0_addr == a);
      assign hit1 = byp_en && we1 && (wr1_addr == a);
      assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 :
                                           hit1 ? wr1_data :
                                           hit0 ? wr0_data : regs_q[a];
      assign rd_busy[k] = !zero && busy_q[a] && !(hit0 || hit1);
   end
endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp: driver pushes model predictions per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_grf_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic        wr0_en, wr1_en, issue_en;
   logic [4:0]  wr0_addr, wr1_addr, issue_addr;
   logic [31:0] wr0_data, wr1_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [5:0]  busy_count;

   grf_mp dut (
      .clk(clk), .reset(reset),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .issue_en(issue_en), .issue_addr(issue_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic [63:0] data;
      logic [1:0]  busy;
      logic [5:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_mem [32];
   bit          m_busy [32];
   int          checks = 0;
   int          fails  = 0;

   // Architectural model: predicts this cycle's outputs, then commits the edge.
   task automatic do_cycle(input bit chk, input bit rst,
                           input bit w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                           input bit w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                           input bit ie, input logic [4:0] ia,
                           input logic [4:0] ra0, input logic [4:0] ra1);
      exp_t        e;
      logic [4:0]  a;
      int          pc;
      reset = rst; wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
      wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
      issue_en = ie; issue_addr = ia; rd_addr = {ra1, ra0};
      if (chk) begin
         e.addr = {ra1, ra0};
         for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? ra0 : ra1;
            if (a == 0) begin
               e.data[k*32 +: 32] = 32'h0;
               e.busy[k] = 1'b0;
            end else begin
               if (!rst && w1e && w1a == a)      e.data[k*32 +: 32] = w1d;
               else if (!rst && w0e && w0a == a) e.data[k*32 +: 32] = w0d;
               else                              e.data[k*32 +: 32] = m_mem[a];
               e.busy[k] = m_busy[a] && !(!rst && ((w0e && w0a == a) || (w1e && w1a == a)));
            end
         end
         pc = 0;
         for (int i = 0; i < 32; i++) pc += int'(m_busy[i]);
         e.cnt = 6'(pc);
         sb.push_back(e);
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (w0e && w0a != 0) begin m_mem[w0a] = w0d; m_busy[w0a] = 1'b0; end
         if (w1e && w1a != 0) begin m_mem[w1a] = w1d; m_busy[w1a] = 1'b0; end
         if (ie && ia != 0) m_busy[ia] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      do_cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, a0, a1);
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 3;
            if (rd_data !== e.data) begin
               fails++;
               $display("FAIL rd_data addr=%h got %h exp %h", e.addr, rd_data, e.data);
            end
            if (rd_busy !== e.busy) begin
               fails++;
               $display("FAIL rd_busy addr=%h got %b exp %b", e.addr, rd_busy, e.busy);
            end
            if (busy_count !== e.cnt) begin
               fails++;
               $display("FAIL busy_count got %0d exp %0d", busy_count, e.cnt);
            end
         end
      end
   end

   initial begin : driver
      do_cycle(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i += 2) rd(5'(i), 5'(i + 1));
      // Same-address dual write: port 1 wins, bypassed then stored.
      do_cycle(1, 0, 1, 5'd5, 32'h1234_5678, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 5'd5, 5'd5);
      rd(5'd5, 5'd0);
      do_cycle(1, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd5);
      rd(5'd0, 5'd0);
      do_cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd9);
      do_cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd7, 5'd9);
      do_cycle(1, 0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h42, 0, 5'd0, 5'd7, 5'd9);
      rd(5'd7, 5'd9);
      do_cycle(1, 0, 1, 5'd3, 32'h99, 0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0);
      rd(5'd3, 5'd9);
      for (int n = 0; n < 600; n++) begin
         do_cycle(1, ($urandom_range(0, 63) == 0),
                  $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
                  $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
                  $urandom_range(0, 2) != 0, rnd_addr(),
                  rnd_addr(), rnd_addr());
      end
      for (int i = 1; i < 32; i++)
         do_cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'(i), 5'(i), 5'd4);
      rd(5'd4, 5'd31);
      do_cycle(1, 1, 1, 5'd4, 32'hCAFE_F00D, 0, 5'd0, 32'h0, 1, 5'd6, 5'd4, 5'd6);
      rd(5'd4, 5'd6);
      rd(5'd31, 5'd1);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
